// File: rtl/r2n_buffer.sv
// r2n_buffer: converts the MAC cores' blocked output (BLOCK_SIZE x BLOCK_SIZE
// tiles, strip-major order) back into row-major rows. A strip of BLOCK_SIZE rows
// is collected in one of two ping-pong banks while the other bank drains one
// full row per handshake.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                start of frame (sampled in IDLE only)
//   in_valid/in_ready block handshake, in_block element (r,c) at lane c*BS+r
//   out_valid/out_ready row handshake, out_row column 0 at the MSB
//   out_last          final row of the frame
//   frame_done        one-cycle pulse after the final row is taken
//   err               (only with R2N_ERR_FLAG_EN) sticky protocol-misuse flag:
//                     in_valid outside ACTIVE, or en outside IDLE
//
// Optional feature macro: R2N_ERR_FLAG_EN.
module r2n_buffer #(
  parameter int WIDTH      = 16,
  parameter int ROW        = 64,
  parameter int COL        = 64,
  parameter int BLOCK_SIZE = 2,
  parameter int IN_WIDTH   = WIDTH * BLOCK_SIZE * BLOCK_SIZE,
  parameter int OUT_WIDTH  = WIDTH * COL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_block,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_row,
  output logic                 out_last,
  output logic                 frame_done
`ifdef R2N_ERR_FLAG_EN
  ,
  output logic                 err
`endif
);

  localparam int CB  = COL / BLOCK_SIZE;  // blocks per strip
  localparam int NS  = ROW / BLOCK_SIZE;  // strips per frame
  localparam int BW  = (CB > 1) ? $clog2(CB) : 1;
  localparam int SW  = $clog2(NS + 1);
  localparam int RW  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int RSW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH, S_DONE} state_t;

  state_t r_state, w_state_next;

  logic [OUT_WIDTH-1:0] r_bank [2][BLOCK_SIZE];
  logic [1:0]           r_bank_full, w_bank_full_next;
  logic                 r_wr_bank, r_rd_bank;
  logic [BW-1:0]        r_blk_cnt;
  logic [SW-1:0]        r_wr_strip;
  logic [RW-1:0]        r_rd_row;
  logic [RSW-1:0]       r_rd_strip;

  logic w_start, w_in_fire, w_out_fire, w_strip_filled, w_strip_drained;

  assign in_ready  = (r_state == S_ACTIVE) && !r_bank_full[r_wr_bank];
  assign out_valid = r_bank_full[r_rd_bank];
  assign out_row   = r_bank[r_rd_bank][r_rd_row];
  assign out_last  = out_valid && (r_rd_strip == RSW'(NS - 1)) &&
                     (r_rd_row == RW'(BLOCK_SIZE - 1));

  assign w_start         = (r_state == S_IDLE) && en;
  assign w_in_fire       = in_valid && in_ready;
  assign w_out_fire      = out_valid && out_ready;
  assign w_strip_filled  = w_in_fire && (r_blk_cnt == BW'(CB - 1));
  assign w_strip_drained = w_out_fire && (r_rd_row == RW'(BLOCK_SIZE - 1));

  // Next state and state-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    frame_done   = 1'b0;
    case (r_state)
      S_IDLE:   if (en) w_state_next = S_ACTIVE;
      S_ACTIVE: if (w_strip_filled && (r_wr_strip == SW'(NS - 1))) w_state_next = S_FLUSH;
      S_FLUSH:  if (w_out_fire && out_last) w_state_next = S_DONE;
      S_DONE: begin
        frame_done   = 1'b1;
        w_state_next = S_IDLE;
      end
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Fill sets and drain clears always target different banks, so both apply.
  always_comb begin
    w_bank_full_next = r_bank_full;
    if (w_start) begin
      w_bank_full_next = 2'b00;
    end else begin
      if (w_strip_filled)  w_bank_full_next[r_wr_bank] = 1'b1;
      if (w_strip_drained) w_bank_full_next[r_rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bank_full <= 2'b00;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_blk_cnt   <= '0;
      r_wr_strip  <= '0;
      r_rd_row    <= '0;
      r_rd_strip  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_bank_full <= w_bank_full_next;
      if (w_start) begin
        r_wr_bank  <= 1'b0;
        r_rd_bank  <= 1'b0;
        r_blk_cnt  <= '0;
        r_wr_strip <= '0;
        r_rd_row   <= '0;
        r_rd_strip <= '0;
      end else begin
        if (w_in_fire) begin
          if (w_strip_filled) begin
            r_blk_cnt  <= '0;
            r_wr_bank  <= ~r_wr_bank;
            r_wr_strip <= r_wr_strip + SW'(1);
          end else begin
            r_blk_cnt <= r_blk_cnt + BW'(1);
          end
        end
        if (w_out_fire) begin
          if (w_strip_drained) begin
            r_rd_row   <= '0;
            r_rd_bank  <= ~r_rd_bank;
            r_rd_strip <= r_rd_strip + RSW'(1);
          end else begin
            r_rd_row <= r_rd_row + RW'(1);
          end
        end
      end
    end
  end

  // Scatter an accepted block into the BLOCK_SIZE rows of the write bank;
  // block column c lands at row column blk_cnt*BLOCK_SIZE+c (column 0 at MSB).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < BLOCK_SIZE; r++) begin
          r_bank[b][r] <= '0;
        end
      end
    end else if (w_in_fire) begin
      for (int r = 0; r < BLOCK_SIZE; r++) begin
        for (int c = 0; c < BLOCK_SIZE; c++) begin
          r_bank[r_wr_bank][r][(COL - 1 - (int'(r_blk_cnt) * BLOCK_SIZE + c)) * WIDTH +: WIDTH]
            <= in_block[(c * BLOCK_SIZE + r) * WIDTH +: WIDTH];
        end
      end
    end
  end

`ifdef R2N_ERR_FLAG_EN
  logic r_err;

  // A frame start wipes any earlier misuse record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_start) begin
      r_err <= 1'b0;
    end else if ((in_valid && (r_state != S_ACTIVE)) || (en && (r_state != S_IDLE))) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_r2n_buffer.sv
module tb_r2n_buffer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Small instance: ROW=4, COL=4 (2 strips of 2 blocks).
  logic        en, in_valid, in_ready, out_valid, out_ready, out_last, frame_done;
  logic [63:0] in_block, out_row;
  // Taller instance: ROW=8, COL=4 (4 strips) so both banks can fill mid-frame.
  logic        en8, iv8, ir8, ov8, or8, last8, done8;
  logic [63:0] ib8, orow8;
`ifdef R2N_ERR_FLAG_EN
  logic err, err8;
`endif

  r2n_buffer #(.WIDTH(16), .ROW(4), .COL(4), .BLOCK_SIZE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_last(out_last), .frame_done(frame_done)
`ifdef R2N_ERR_FLAG_EN
    , .err(err)
`endif
  );

  r2n_buffer #(.WIDTH(16), .ROW(8), .COL(4), .BLOCK_SIZE(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .in_valid(iv8), .in_ready(ir8),
    .in_block(ib8), .out_valid(ov8), .out_ready(or8),
    .out_row(orow8), .out_last(last8), .frame_done(done8)
`ifdef R2N_ERR_FLAG_EN
    , .err(err8)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame with element (R,C) = 0x10*R + C; block b covers strip b/2, column-block b%2.
  function automatic logic [63:0] blk_val(input int b);
    logic [63:0] res;
    res = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        res[(c*2+r)*16 +: 16] = 16'(16 * ((b/2)*2 + r) + (b%2)*2 + c);
    return res;
  endfunction

  function automatic logic [63:0] row_val(input int rr);
    logic [63:0] res;
    for (int k = 0; k < 4; k++) res[(3-k)*16 +: 16] = 16'(16 * rr + k);
    return res;
  endfunction

  // Random frame for the tall instance, kept as a plain row-major picture.
  logic [15:0] frm8 [8][4];

  function automatic logic [63:0] blk8(input int b);
    logic [63:0] res;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        res[(c*2+r)*16 +: 16] = frm8[(b/2)*2 + r][(b%2)*2 + c];
    return res;
  endfunction

  function automatic logic [63:0] row8(input int rr);
    logic [63:0] res;
    for (int k = 0; k < 4; k++) res[(3-k)*16 +: 16] = frm8[rr][k];
    return res;
  endfunction

  typedef struct {
    logic        en;
    logic        iv;
    int          blk;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic        chk_row;
    logic [63:0] e_row;
    logic        e_last;
    logic        e_done;
  } vec_t;

  vec_t tbl [9];

  task automatic run_table(input string tag);
    for (int i = 0; i < 9; i++) begin
      en        = tbl[i].en;
      in_valid  = tbl[i].iv;
      in_block  = blk_val(tbl[i].blk);
      out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("%s c%0d in_ready", tag, i), 64'(in_ready), 64'(tbl[i].e_ir));
      chk($sformatf("%s c%0d out_valid", tag, i), 64'(out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("%s c%0d out_last", tag, i), 64'(out_last), 64'(tbl[i].e_last));
      chk($sformatf("%s c%0d frame_done", tag, i), 64'(frame_done), 64'(tbl[i].e_done));
      if (tbl[i].chk_row) chk($sformatf("%s c%0d out_row", tag, i), out_row, tbl[i].e_row);
      $display("%s cycle %0d: in_ready=%b out_valid=%b out_row=%h last=%b done=%b",
               tag, i, in_ready, out_valid, out_row, out_last, frame_done);
      tick();
    end
    en = 0; in_valid = 0;
  endtask

  initial begin
    int acc, nrows, ndone, cyc, phase, rows, started;
    logic e_ir, e_ov;

    //            en iv blk ordy  ir ov chk row                     last done
    tbl[0] = '{1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0,                 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0,                 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0,                 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 2, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0000_0001_0002_0003, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0010_0011_0012_0013, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0020_0021_0022_0023, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0030_0031_0032_0033, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                 1'b0, 1'b0};

    rst_n = 0; en = 0; in_valid = 0; in_block = '0; out_ready = 0;
    en8 = 0; iv8 = 0; ib8 = '0; or8 = 0;
    #12;
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_row", out_row, 64'd0);
    chk("reset out_last", 64'(out_last), 64'd0);
    chk("reset frame_done", 64'(frame_done), 64'd0);
    #10 rst_n = 1;
    tick();

    // Basic frame, including the one-cycle strip latency and the DONE pulse.
    run_table("basic");

    // Backpressure: out_ready low while six blocks are offered.
    en = 1; tick(); en = 0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_block = blk_val(acc % 4); out_ready = 0;
      @(negedge clk);
      chk($sformatf("bp offer %0d in_ready", i), 64'(in_ready), 64'(i < 4));
      $display("bp offer %0d: in_ready=%b out_valid=%b", i, in_ready, out_valid);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 0;
    @(negedge clk);
    chk("bp stall out_valid", 64'(out_valid), 64'd1);
    chk("bp stall out_row", out_row, row_val(0));
    tick();
    out_ready = 1;
    nrows = 0; ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) begin
        chk($sformatf("bp row %0d", nrows), out_row, row_val(nrows));
        chk($sformatf("bp row %0d last", nrows), 64'(out_last), 64'(nrows == 3));
        $display("bp drain row %0d: %h last=%b", nrows, out_row, out_last);
        nrows++;
      end
      if (frame_done) ndone++;
      tick();
    end
    chk("bp row count", 64'(nrows), 64'd4);
    chk("bp done pulses", 64'(ndone), 64'd1);
    out_ready = 0;

    // Reset mid-frame after three blocks, then a clean frame.
    en = 1; tick(); en = 0;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1; in_block = blk_val(b); tick();
    end
    in_valid = 0;
    #2;
    chk("pre-reset out_valid", 64'(out_valid), 64'd1);
    rst_n = 0;
    #1;
    chk("async reset out_valid", 64'(out_valid), 64'd0);
    chk("async reset in_ready", 64'(in_ready), 64'd0);
    chk("async reset out_row", out_row, 64'd0);
    $display("mid-frame reset: out_valid=%b in_ready=%b out_row=%h", out_valid, in_ready, out_row);
    @(negedge clk);
    rst_n = 1;
    tick();
    run_table("after-reset");

`ifdef R2N_ERR_FLAG_EN
    chk("err clear", 64'(err), 64'd0);
    in_valid = 1; tick(); in_valid = 0;
    chk("err set", 64'(err), 64'd1);
    tick(); tick();
    chk("err sticky", 64'(err), 64'd1);
    en = 1; tick(); en = 0;
    chk("err cleared by start", 64'(err), 64'd0);
    $display("err sequence done: err=%b", err);
    rst_n = 0; #2; rst_n = 1; tick();
`endif

    // Randomized frames on the tall instance against a counting model:
    // strips filled = accepted/2, strips drained = rows/2, at most 2 held.
    for (int f = 0; f < 4; f++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 4; c++) frm8[r][c] = 16'($urandom);
      phase = 0; acc = 0; rows = 0; started = 0; cyc = 0;
      while (!(phase == 0 && started == 1) && cyc < 600) begin
        cyc++;
        en8 = (phase == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
        iv8 = ($urandom_range(0, 9) < 6);
        ib8 = (acc < 8) ? blk8(acc) : {$urandom, $urandom};
        or8 = 1'($urandom_range(0, 1));
        e_ir = (phase == 1) && (acc < 8) && ((acc / 2) - (rows / 2) < 2);
        e_ov = (acc / 2) > (rows / 2);
        @(negedge clk);
        chk($sformatf("rnd f%0d c%0d in_ready", f, cyc), 64'(ir8), 64'(e_ir));
        chk($sformatf("rnd f%0d c%0d out_valid", f, cyc), 64'(ov8), 64'(e_ov));
        chk($sformatf("rnd f%0d c%0d out_last", f, cyc), 64'(last8), 64'(e_ov && rows == 7));
        chk($sformatf("rnd f%0d c%0d frame_done", f, cyc), 64'(done8), 64'(phase == 2));
        if (e_ov) chk($sformatf("rnd f%0d row %0d", f, rows), orow8, row8(rows));
        if (iv8 && e_ir) $display("rnd f%0d c%0d: block %0d accepted", f, cyc, acc);
        if (e_ov && or8) $display("rnd f%0d c%0d: row %0d = %h", f, cyc, rows, orow8);
        if (phase == 0) begin
          if (en8) begin phase = 1; started = 1; acc = 0; rows = 0; end
        end else if (phase == 1) begin
          if (iv8 && e_ir) acc++;
          if (e_ov && or8) rows++;
          if (rows == 8) phase = 2;
        end else begin
          phase = 0;
        end
        tick();
      end
      if (cyc >= 600) chk($sformatf("rnd f%0d completed within budget", f), 64'd0, 64'd1);
    end
    en8 = 0; iv8 = 0; or8 = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
